prime_trial_ctrl: RTL and testbench
===================================

Name: prime_trial_ctrl

Overview:
Trial-division sequencer that sits directly upstream of the combinational divider stage in the prime-detection datapath. It accepts one candidate per handshake and issues (candidate, divisor) pairs to the divider for divisors 2, 3, 4, … while divisor² ≤ candidate. It consumes each returned remainder and reports whether the candidate is prime, together with the smallest factor found.

Parameters:
nbits, 16, width of the candidate, divisor, factor and divider operands

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_n  input  nbits  candidate number
in_val  input  1  candidate valid
in_rdy  output  1  block ready to accept a candidate
div_opa  output  nbits  dividend to the divider (always the latched candidate)
div_opb  output  nbits  divisor to the divider
div_istream_val  output  1  divide request valid
div_istream_rdy  input  1  divider ready for a request
div_result  input  nbits  remainder of div_opa mod div_opb
div_ostream_val  input  1  divider result valid
div_ostream_rdy  output  1  block ready to consume a result
out_prime  output  1  1 = candidate is prime
out_factor  output  nbits  smallest divisor found; 0 if prime or candidate < 2
out_val  output  1  result valid
out_rdy  input  1  consumer ready

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset state is IDLE. Register values on reset:
  - in_rdy=1; out_val=0; out_prime=0; out_factor=0.
  - div_istream_val=0; div_ostream_rdy=0.
  - Internal n and d registers are 0.
- Reset mid-operation: abandon the candidate and return to IDLE; no result is produced.
- A transfer on any interface occurs when val && rdy are both high on a rising edge.
- States and transitions:
  - IDLE: in_rdy=1. On an in transfer, latch n=in_n and set d=2, then go to CHECK.
  - CHECK (1 cycle): compute d*d at 2*nbits width, so there is no overflow.
    - n < 2: prime=0, factor=0, go to DONE.
    - d*d > n: prime=1, factor=0, go to DONE.
    - Otherwise go to ISSUE.
  - ISSUE: div_istream_val=1, div_opa=n, div_opb=d. Hold these stable until div_istream_rdy, then go to WAIT.
  - WAIT: div_ostream_rdy=1. On a result transfer:
    - div_result==0: prime=0, factor=d, go to DONE.
    - Otherwise d=d+1 and go to CHECK.
  - DONE: out_val=1 and outputs held stable until out_rdy. On the out transfer, go to IDLE; in_rdy rises the following cycle.
- Only one divide request is outstanding at a time. div_ostream_rdy is 0 outside WAIT, and div_istream_val is 0 outside ISSUE.
- div_opa and div_opb drive the registered n and d in every state, not only in ISSUE.
- d is nbits wide. d never exceeds 2^(nbits/2) because CHECK terminates first, so there is no wrap-around.
- Cost per divisor is at least 3 cycles (CHECK, ISSUE, WAIT), plus any divider stalls. DONE adds 1 cycle plus consumer back-pressure.
- in_rdy is 0 in every state except IDLE; candidates are never buffered.

Test Plan:
- n=97 -> divisors 2..9 issued (8 requests), all remainders nonzero; out_prime=1, out_factor=0.
- n=91 -> requests d=2..7, d=7 returns remainder 0; out_prime=0, out_factor=7, no request for d=8.
- n=0, n=1, n=2, n=3 in sequence -> (0,0), (0,0), (1,0), (1,0); no divide requests for any of them.
- n=65521 (nbits=16) -> last request d=255, CHECK at d=256 (65536 > 65521) ends the loop; out_prime=1. n=65535 -> out_factor=3.
- Back-pressure:
  - Hold div_istream_rdy=0 for 5 cycles, hold div_ostream_val=0 for 3 cycles, and hold out_rdy=0 for 4 cycles.
  - Required: div_opa, div_opb and the outputs stay stable throughout, and in_rdy stays 0 until the out transfer.
  - Result for n=49 is factor 7.
- Reset asserted during WAIT for n=221 -> next cycle in_rdy=1, out_val=0, div_*_val and div_ostream_rdy are 0. Then n=221 -> out_factor=13.

Source files
------------

// File: rtl/prime_trial_ctrl.sv
// Trial-division sequencer: feeds (candidate, divisor) pairs to an external
// divider and reports primality plus the smallest factor found.
module prime_trial_ctrl #(
    parameter int nbits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] in_n,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [nbits-1:0] div_opa,
    output logic [nbits-1:0] div_opb,
    output logic             div_istream_val,
    input  logic             div_istream_rdy,
    input  logic [nbits-1:0] div_result,
    input  logic             div_ostream_val,
    output logic             div_ostream_rdy,
    output logic             out_prime,
    output logic [nbits-1:0] out_factor,
    output logic             out_val,
    input  logic             out_rdy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [nbits-1:0] D_START = nbits'(2);
    localparam logic [nbits-1:0] D_STEP  = nbits'(1);
    localparam logic [nbits-1:0] ZERO_N  = {nbits{1'b0}};

    state_t           state_r;
    state_t           state_next_s;
    logic [nbits-1:0] n_r;
    logic [nbits-1:0] n_next_s;
    logic [nbits-1:0] d_r;
    logic [nbits-1:0] d_next_s;
    logic             prime_r;
    logic             prime_next_s;
    logic [nbits-1:0] factor_r;
    logic [nbits-1:0] factor_next_s;
    logic             in_rdy_r;
    logic             istream_val_r;
    logic             ostream_rdy_r;
    logic             out_val_r;

    // Squaring at double width means d*d can never wrap before exceeding n.
    logic [2*nbits-1:0] d_sq_s;
    logic [2*nbits-1:0] n_wide_s;

    assign d_sq_s   = {{nbits{1'b0}}, d_r} * {{nbits{1'b0}}, d_r};
    assign n_wide_s = {{nbits{1'b0}}, n_r};

    // Next-state and datapath-update logic for the sequencer.
    always_comb begin
        state_next_s  = state_r;
        n_next_s      = n_r;
        d_next_s      = d_r;
        prime_next_s  = prime_r;
        factor_next_s = factor_r;
        case (state_r)
            ST_IDLE: begin
                if (in_val && in_rdy_r) begin
                    n_next_s     = in_n;
                    d_next_s     = D_START;
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (n_r < D_START) begin
                    prime_next_s  = 1'b0;
                    factor_next_s = ZERO_N;
                    state_next_s  = ST_DONE;
                end else if (d_sq_s > n_wide_s) begin
                    prime_next_s  = 1'b1;
                    factor_next_s = ZERO_N;
                    state_next_s  = ST_DONE;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (istream_val_r && div_istream_rdy) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (div_ostream_val && ostream_rdy_r) begin
                    if (div_result == ZERO_N) begin
                        prime_next_s  = 1'b0;
                        factor_next_s = d_r;
                        state_next_s  = ST_DONE;
                    end else begin
                        d_next_s     = d_r + D_STEP;
                        state_next_s = ST_CHECK;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (out_val_r && out_rdy) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath registers and handshake flags, decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            n_r           <= ZERO_N;
            d_r           <= ZERO_N;
            prime_r       <= 1'b0;
            factor_r      <= ZERO_N;
            in_rdy_r      <= 1'b1;
            istream_val_r <= 1'b0;
            ostream_rdy_r <= 1'b0;
            out_val_r     <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            n_r           <= n_next_s;
            d_r           <= d_next_s;
            prime_r       <= prime_next_s;
            factor_r      <= factor_next_s;
            in_rdy_r      <= (state_next_s == ST_IDLE);
            istream_val_r <= (state_next_s == ST_ISSUE);
            ostream_rdy_r <= (state_next_s == ST_WAIT);
            out_val_r     <= (state_next_s == ST_DONE);
        end
    end

    assign in_rdy          = in_rdy_r;
    assign div_opa         = n_r;
    assign div_opb         = d_r;
    assign div_istream_val = istream_val_r;
    assign div_ostream_rdy = ostream_rdy_r;
    assign out_prime       = prime_r;
    assign out_factor      = factor_r;
    assign out_val         = out_val_r;

    prime_trial_ctrl_chk #(.nbits(nbits)) u_chk (
        .clk             (clk),
        .reset           (reset),
        .in_rdy          (in_rdy_r),
        .div_opa         (n_r),
        .div_opb         (d_r),
        .div_istream_val (istream_val_r),
        .div_istream_rdy (div_istream_rdy),
        .div_ostream_rdy (ostream_rdy_r),
        .out_prime       (prime_r),
        .out_factor      (factor_r),
        .out_val         (out_val_r),
        .out_rdy         (out_rdy)
    );

endmodule

// Protocol properties for the sequencer's handshakes.
module prime_trial_ctrl_chk #(
    parameter int nbits = 16
) (
    input logic             clk,
    input logic             reset,
    input logic             in_rdy,
    input logic [nbits-1:0] div_opa,
    input logic [nbits-1:0] div_opb,
    input logic             div_istream_val,
    input logic             div_istream_rdy,
    input logic             div_ostream_rdy,
    input logic             out_prime,
    input logic [nbits-1:0] out_factor,
    input logic             out_val,
    input logic             out_rdy
);

    a_idle_exclusive : assert property (@(posedge clk) disable iff (reset)
        in_rdy |-> !(div_istream_val || div_ostream_rdy || out_val));

    a_one_outstanding : assert property (@(posedge clk) disable iff (reset)
        !(div_istream_val && div_ostream_rdy));

    a_req_hold : assert property (@(posedge clk) disable iff (reset)
        (div_istream_val && !div_istream_rdy) |=>
            (div_istream_val && $stable(div_opa) && $stable(div_opb)));

    a_out_hold : assert property (@(posedge clk) disable iff (reset)
        (out_val && !out_rdy) |=>
            (out_val && $stable(out_prime) && $stable(out_factor)));

endmodule

// File: tb/tb_prime_trial_ctrl.sv
// Directed bench for prime_trial_ctrl; the bench itself plays the divider.
module tb_prime_trial_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] in_n;
    logic        in_val;
    logic        in_rdy;
    logic [15:0] div_opa;
    logic [15:0] div_opb;
    logic        div_istream_val;
    logic        div_istream_rdy;
    logic [15:0] div_result;
    logic        div_ostream_val;
    logic        div_ostream_rdy;
    logic        out_prime;
    logic [15:0] out_factor;
    logic        out_val;
    logic        out_rdy;

    int passed = 0;
    int total  = 0;

    prime_trial_ctrl #(.nbits(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_n            (in_n),
        .in_val          (in_val),
        .in_rdy          (in_rdy),
        .div_opa         (div_opa),
        .div_opb         (div_opb),
        .div_istream_val (div_istream_val),
        .div_istream_rdy (div_istream_rdy),
        .div_result      (div_result),
        .div_ostream_val (div_ostream_val),
        .div_ostream_rdy (div_ostream_rdy),
        .out_prime       (out_prime),
        .out_factor      (out_factor),
        .out_val         (out_val),
        .out_rdy         (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Push one candidate, act as the divider, then drain the result.
    task automatic run_candidate(input logic [15:0] n, input logic exp_prime,
                                 input logic [15:0] exp_factor, input int exp_reqs,
                                 input logic [15:0] exp_last, input int istall,
                                 input int ostall, input int outstall);
        int          reqs = 0;
        logic [15:0] last = 16'd0;
        logic        have = 1'b0;
        logic [15:0] rem  = 16'd0;
        logic        done = 1'b0;
        check("in_rdy_before", in_rdy, 1);
        in_n   = n;
        in_val = 1'b1;
        @(posedge clk); #1;
        in_val = 1'b0;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            if (out_val) begin
                done = 1'b1;
            end else begin
                div_istream_rdy = 1'b0;
                div_ostream_val = 1'b0;
                if (div_istream_val) begin
                    if (istall > 0) begin
                        check("istall_opa", div_opa, n);
                        check("istall_opb", div_opb, 16'd2);
                        check("istall_in_rdy", in_rdy, 0);
                        istall--;
                    end else begin
                        div_istream_rdy = 1'b1;
                        reqs++;
                        last = div_opb;
                        rem  = div_opa % div_opb;
                        have = 1'b1;
                    end
                end
                if (div_ostream_rdy && have) begin
                    if (ostall > 0) begin
                        check("ostall_opa", div_opa, n);
                        check("ostall_opb", div_opb, 16'd2);
                        check("ostall_in_rdy", in_rdy, 0);
                        ostall--;
                    end else begin
                        div_ostream_val = 1'b1;
                        div_result      = rem;
                        have            = 1'b0;
                    end
                end
                @(posedge clk); #1;
            end
        end
        div_istream_rdy = 1'b0;
        div_ostream_val = 1'b0;
        check("result_timeout", done, 1);
        check("out_prime", out_prime, exp_prime);
        check("out_factor", out_factor, exp_factor);
        check("request_count", reqs, exp_reqs);
        check("last_divisor", last, exp_last);
        if (!done) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end else begin
            for (int k = 0; k < outstall; k++) begin
                check("hold_out_val", out_val, 1);
                check("hold_prime", out_prime, exp_prime);
                check("hold_factor", out_factor, exp_factor);
                check("hold_in_rdy", in_rdy, 0);
                @(posedge clk); #1;
            end
            out_rdy = 1'b1;
            @(posedge clk); #1;
            out_rdy = 1'b0;
            check("after_out_val", out_val, 0);
            check("after_in_rdy", in_rdy, 1);
        end
    endtask

    initial begin
        logic seen_wait;
        reset           = 1'b1;
        in_n            = 16'd0;
        in_val          = 1'b0;
        div_istream_rdy = 1'b0;
        div_result      = 16'd0;
        div_ostream_val = 1'b0;
        out_rdy         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_val", out_val, 0);
        check("rst_out_prime", out_prime, 0);
        check("rst_out_factor", out_factor, 0);
        check("rst_istream_val", div_istream_val, 0);
        check("rst_ostream_rdy", div_ostream_rdy, 0);
        check("rst_opa", div_opa, 0);
        check("rst_opb", div_opb, 0);

        run_candidate(16'd97,    1'b1, 16'd0, 8,   16'd9,   0, 0, 0);
        run_candidate(16'd91,    1'b0, 16'd7, 6,   16'd7,   0, 0, 0);
        run_candidate(16'd0,     1'b0, 16'd0, 0,   16'd0,   0, 0, 0);
        run_candidate(16'd1,     1'b0, 16'd0, 0,   16'd0,   0, 0, 0);
        run_candidate(16'd2,     1'b1, 16'd0, 0,   16'd0,   0, 0, 0);
        run_candidate(16'd3,     1'b1, 16'd0, 0,   16'd0,   0, 0, 0);
        run_candidate(16'd65521, 1'b1, 16'd0, 254, 16'd255, 0, 0, 0);
        run_candidate(16'd65535, 1'b0, 16'd3, 2,   16'd3,   0, 0, 0);
        run_candidate(16'd49,    1'b0, 16'd7, 6,   16'd7,   5, 3, 4);

        // Abandon n=221 while the first divide result is outstanding.
        in_n   = 16'd221;
        in_val = 1'b1;
        @(posedge clk); #1;
        in_val    = 1'b0;
        seen_wait = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen_wait; cyc++) begin
            div_istream_rdy = div_istream_val;
            if (div_ostream_rdy) begin
                seen_wait = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("reach_wait", seen_wait, 1);
        div_istream_rdy = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_in_rdy", in_rdy, 1);
        check("midrst_out_val", out_val, 0);
        check("midrst_istream_val", div_istream_val, 0);
        check("midrst_ostream_rdy", div_ostream_rdy, 0);

        run_candidate(16'd221,   1'b0, 16'd13, 12, 16'd13,  0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
